// File: rtl/spi_pkg.sv
// rtl/spi_pkg.sv - shared types and constants for the SPI request arbiter
package spi_pkg;

  localparam int SPI_DATA_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    BUSY  = 2'd2,
    DONE  = 2'd3
  } arb_state_t;

  // Index width for a requester count, never narrower than one bit.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - combinational round-robin selector starting after last_idx
module rr_pick
  import spi_pkg::*;
#(
  parameter int NUM_REQ = 3,
  parameter int IDX_W   = idx_width(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   last_idx,
  output logic [IDX_W-1:0]   idx,
  output logic               valid
);

  logic [IDX_W-1:0] cand;

  // Walk upward from last_idx+1 with wrap; the first set request wins.
  always_comb begin
    cand  = last_idx;
    idx   = '0;
    valid = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (cand == IDX_W'(NUM_REQ - 1)) begin
        cand = '0;
      end else begin
        cand = cand + IDX_W'(1);
      end
      if (!valid && req[cand]) begin
        idx   = cand;
        valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/spi_req_arbiter.sv
// rtl/spi_req_arbiter.sv - round-robin arbiter sharing one SPI master among requesters
module spi_req_arbiter
  import spi_pkg::*;
#(
  parameter int NUM_REQ        = 3,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic [NUM_REQ-1:0]                req,
  input  logic [NUM_REQ-1:0]                req_tx,
  input  logic [NUM_REQ-1:0]                req_rx,
  input  logic [SPI_DATA_WIDTH*NUM_REQ-1:0] req_tx_data,
  output logic [NUM_REQ-1:0]                grant,
  output logic [NUM_REQ-1:0]                done,
  output logic                              timeout_err,
  output logic [SPI_DATA_WIDTH-1:0]         rx_data,
  output logic                              m_tx_start,
  output logic                              m_rx_start,
  output logic [SPI_DATA_WIDTH-1:0]         m_tx_data,
  input  logic                              m_tx_done,
  input  logic                              m_rx_valid,
  input  logic [SPI_DATA_WIDTH-1:0]         m_rx_data
);

  localparam int IDX_W = idx_width(NUM_REQ);
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  arb_state_t state_q, state_d;

  logic [IDX_W-1:0] idx_q;
  logic [IDX_W-1:0] last_idx_q;
  logic             tx_q;
  logic             rx_q;
  logic             timed_out_q;
  logic [CNT_W-1:0] cnt_q;

  logic [IDX_W-1:0] pick_idx;
  logic             pick_valid;

  logic grant_take;
  logic complete;
  logic timeout_hit;
  logic finish;

  logic [SPI_DATA_WIDTH-1:0] tx_bytes [NUM_REQ];

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_bytes
    assign tx_bytes[g] = req_tx_data[g*SPI_DATA_WIDTH +: SPI_DATA_WIDTH];
  end

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr_pick (
    .req      (req),
    .last_idx (last_idx_q),
    .idx      (pick_idx),
    .valid    (pick_valid)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state, master start strobes and datapath control strobes.
  always_comb begin
    state_d     = state_q;
    m_tx_start  = 1'b0;
    m_rx_start  = 1'b0;
    grant_take  = 1'b0;
    complete    = 1'b0;
    timeout_hit = 1'b0;
    finish      = 1'b0;
    case (state_q)
      IDLE: begin
        if (pick_valid) begin
          grant_take = 1'b1;
          state_d    = ISSUE;
        end
      end
      ISSUE: begin
        m_tx_start = tx_q;
        m_rx_start = rx_q;
        state_d    = (tx_q || rx_q) ? BUSY : DONE;
      end
      BUSY: begin
        // A completion in the final counted cycle still counts as completion.
        if (m_tx_done || m_rx_valid) begin
          complete = 1'b1;
          state_d  = DONE;
        end else if (cnt_q == CNT_LAST) begin
          timeout_hit = 1'b1;
          state_d     = DONE;
        end
      end
      DONE: begin
        finish  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Latched transaction, registered outputs and the BUSY cycle counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      idx_q       <= '0;
      last_idx_q  <= IDX_W'(NUM_REQ - 1);
      tx_q        <= 1'b0;
      rx_q        <= 1'b0;
      timed_out_q <= 1'b0;
      cnt_q       <= '0;
      grant       <= '0;
      done        <= '0;
      timeout_err <= 1'b0;
      rx_data     <= '0;
      m_tx_data   <= '0;
    end else begin
      done        <= '0;
      timeout_err <= 1'b0;

      if (state_q == BUSY) begin
        cnt_q <= cnt_q + CNT_W'(1);
      end else begin
        cnt_q <= '0;
      end

      if (grant_take) begin
        idx_q       <= pick_idx;
        tx_q        <= req_tx[pick_idx];
        rx_q        <= req_rx[pick_idx];
        m_tx_data   <= tx_bytes[pick_idx];
        grant       <= NUM_REQ'(1) << pick_idx;
        timed_out_q <= 1'b0;
      end

      if (complete && rx_q) begin
        rx_data <= m_rx_data;
      end

      // The timeout already delivered the done pulse, so DONE stays quiet after it.
      if (timeout_hit) begin
        timeout_err <= 1'b1;
        done        <= NUM_REQ'(1) << idx_q;
        timed_out_q <= 1'b1;
      end

      if (finish) begin
        if (!timed_out_q) begin
          done <= NUM_REQ'(1) << idx_q;
        end
        last_idx_q <= idx_q;
        grant      <= '0;
      end
    end
  end

endmodule

// File: tb/tb_spi_req_arbiter.sv
// tb/tb_spi_req_arbiter.sv - directed self-checking bench for spi_req_arbiter
module tb_spi_req_arbiter;

  logic        clk;
  logic        reset;

  logic [2:0]  req, req_tx, req_rx;
  logic [23:0] req_tx_data;
  logic [2:0]  grant, done;
  logic        timeout_err;
  logic [7:0]  rx_data;
  logic        m_tx_start, m_rx_start;
  logic [7:0]  m_tx_data;
  logic        m_tx_done, m_rx_valid;
  logic [7:0]  m_rx_data;

  logic [2:0]  req_b, req_tx_b, req_rx_b;
  logic [23:0] req_tx_data_b;
  logic [2:0]  grant_b, done_b;
  logic        timeout_err_b;
  logic [7:0]  rx_data_b;
  logic        m_tx_start_b, m_rx_start_b;
  logic [7:0]  m_tx_data_b;
  logic        m_tx_done_b, m_rx_valid_b;
  logic [7:0]  m_rx_data_b;

  int checks;
  int errors;

  spi_req_arbiter #(.NUM_REQ(3), .TIMEOUT_CYCLES(1024)) dut (
    .clk(clk), .reset(reset), .req(req), .req_tx(req_tx), .req_rx(req_rx),
    .req_tx_data(req_tx_data), .grant(grant), .done(done), .timeout_err(timeout_err),
    .rx_data(rx_data), .m_tx_start(m_tx_start), .m_rx_start(m_rx_start),
    .m_tx_data(m_tx_data), .m_tx_done(m_tx_done), .m_rx_valid(m_rx_valid),
    .m_rx_data(m_rx_data)
  );

  spi_req_arbiter #(.NUM_REQ(3), .TIMEOUT_CYCLES(16)) dut_to (
    .clk(clk), .reset(reset), .req(req_b), .req_tx(req_tx_b), .req_rx(req_rx_b),
    .req_tx_data(req_tx_data_b), .grant(grant_b), .done(done_b), .timeout_err(timeout_err_b),
    .rx_data(rx_data_b), .m_tx_start(m_tx_start_b), .m_rx_start(m_rx_start_b),
    .m_tx_data(m_tx_data_b), .m_tx_done(m_tx_done_b), .m_rx_valid(m_rx_valid_b),
    .m_rx_data(m_rx_data_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    tick;
    tick;
    checks++; if (grant !== 3'b000) begin errors++; $display("FAIL reset_grant: got %b expected 000", grant); end
    checks++; if (done !== 3'b000) begin errors++; $display("FAIL reset_done: got %b expected 000", done); end
    checks++; if (timeout_err !== 1'b0) begin errors++; $display("FAIL reset_timeout_err: got %b expected 0", timeout_err); end
    checks++; if (rx_data !== 8'h00) begin errors++; $display("FAIL reset_rx_data: got %h expected 00", rx_data); end
    checks++; if (m_tx_data !== 8'h00) begin errors++; $display("FAIL reset_m_tx_data: got %h expected 00", m_tx_data); end
    checks++; if ({m_tx_start, m_rx_start} !== 2'b00) begin errors++; $display("FAIL reset_starts: got %b expected 00", {m_tx_start, m_rx_start}); end
    checks++; if (grant_b !== 3'b000) begin errors++; $display("FAIL reset_grant_b: got %b expected 000", grant_b); end
    reset = 1'b0;
    tick;
  endtask

  task automatic test_single;
    int tx_pulses, rx_pulses, done_pulses, countdown;
    logic [2:0] gseen, dval;
    logic [7:0] mdata;
    tx_pulses = 0; rx_pulses = 0; done_pulses = 0; countdown = -1;
    gseen = '0; dval = '0; mdata = '0;
    req_tx = 3'b010; req_rx = 3'b010; req_tx_data = 24'h00A500; req = 3'b010;
    for (int c = 0; c < 260; c++) begin
      tick;
      m_tx_done = 1'b0; m_rx_valid = 1'b0;
      if (grant != 3'b000 && gseen == 3'b000) begin gseen = grant; req = 3'b000; end
      if (m_rx_start) rx_pulses++;
      if (m_tx_start) begin
        tx_pulses++;
        mdata = m_tx_data;
        countdown = 200;
      end else if (countdown > 0) begin
        countdown--;
        if (countdown == 0) begin m_tx_done = 1'b1; m_rx_valid = 1'b1; m_rx_data = mdata; end
      end
      if (done != 3'b000) begin done_pulses++; dval = done; end
    end
    checks++; if (gseen !== 3'b010) begin errors++; $display("FAIL single_grant: got %b expected 010", gseen); end
    checks++; if (tx_pulses !== 1) begin errors++; $display("FAIL single_tx_start: got %0d expected 1", tx_pulses); end
    checks++; if (rx_pulses !== 1) begin errors++; $display("FAIL single_rx_start: got %0d expected 1", rx_pulses); end
    checks++; if (mdata !== 8'hA5) begin errors++; $display("FAIL single_m_tx_data: got %h expected a5", mdata); end
    checks++; if (done_pulses !== 1) begin errors++; $display("FAIL single_done_count: got %0d expected 1", done_pulses); end
    checks++; if (dval !== 3'b010) begin errors++; $display("FAIL single_done_value: got %b expected 010", dval); end
    checks++; if (rx_data !== 8'hA5) begin errors++; $display("FAIL single_rx_data: got %h expected a5", rx_data); end
  endtask

  task automatic test_tx_rx_zero;
    int t0, t1, starts;
    logic [2:0] gval, dval;
    t0 = -1; t1 = -1; starts = 0; gval = '0; dval = '0;
    req_tx = 3'b000; req_rx = 3'b000; req = 3'b100;
    for (int c = 0; c < 20; c++) begin
      tick;
      if (m_tx_start || m_rx_start) starts++;
      if (grant != 3'b000 && t0 < 0) begin t0 = c; gval = grant; req = 3'b000; end
      if (done != 3'b000 && t1 < 0) begin t1 = c; dval = done; end
    end
    checks++; if (gval !== 3'b100) begin errors++; $display("FAIL zero_grant: got %b expected 100", gval); end
    checks++; if (starts !== 0) begin errors++; $display("FAIL zero_starts: got %0d expected 0", starts); end
    checks++; if (dval !== 3'b100) begin errors++; $display("FAIL zero_done: got %b expected 100", dval); end
    checks++; if (t1 - t0 !== 2 || t0 < 0) begin errors++; $display("FAIL zero_done_latency: got %0d expected 2", t1 - t0); end
  endtask

  task automatic test_stray_and_drop;
    int st, dn, cd;
    logic gs;
    logic [2:0] dv;
    logic [7:0] md;
    st = 0; dn = 0; cd = -1; gs = 1'b0; dv = '0; md = '0;
    req = 3'b000;
    m_rx_valid = 1'b1; m_tx_done = 1'b1; m_rx_data = 8'hEE;
    tick;
    m_rx_valid = 1'b0; m_tx_done = 1'b0;
    tick;
    checks++; if (rx_data !== 8'hA5) begin errors++; $display("FAIL stray_idle_rx_data: got %h expected a5", rx_data); end
    checks++; if (grant !== 3'b000 || done !== 3'b000) begin errors++; $display("FAIL stray_idle_state: got grant %b done %b expected 000 000", grant, done); end
    req_tx = 3'b001; req_rx = 3'b001; req_tx_data = 24'h00005A; req = 3'b001;
    for (int c = 0; c < 40; c++) begin
      tick;
      m_rx_valid = 1'b0; m_tx_done = 1'b0;
      if (grant != 3'b000 && !gs) begin
        gs = 1'b1; req = 3'b000; req_tx_data = 24'hFFFFFF; req_tx = 3'b000; req_rx = 3'b000;
      end
      if (m_tx_start) begin
        st++; md = m_tx_data;
        m_rx_valid = 1'b1; m_rx_data = 8'h11;
        cd = 5;
      end else if (cd > 0) begin
        cd--;
        if (cd == 0) begin m_rx_valid = 1'b1; m_rx_data = 8'hC3; end
      end
      if (done != 3'b000) begin dn++; dv = done; end
    end
    checks++; if (st !== 1) begin errors++; $display("FAIL drop_tx_start: got %0d expected 1", st); end
    checks++; if (md !== 8'h5A) begin errors++; $display("FAIL drop_issue_data: got %h expected 5a", md); end
    checks++; if (dn !== 1 || dv !== 3'b001) begin errors++; $display("FAIL drop_done: got %0d pulses value %b expected 1 pulse 001", dn, dv); end
    checks++; if (rx_data !== 8'hC3) begin errors++; $display("FAIL drop_rx_data: got %h expected c3", rx_data); end
    checks++; if (m_tx_data !== 8'h5A) begin errors++; $display("FAIL drop_m_tx_data_held: got %h expected 5a", m_tx_data); end
  endtask

  task automatic test_reset_busy;
    logic seen;
    int bad_done;
    seen = 1'b0; bad_done = 0;
    req_tx = 3'b000; req_rx = 3'b000; req = 3'b001;
    for (int c = 0; c < 8; c++) begin
      tick;
      if (grant != 3'b000) req = 3'b000;
    end
    req_tx = 3'b010; req_rx = 3'b000; req_tx_data = 24'h006600; req = 3'b010;
    for (int c = 0; c < 10 && !seen; c++) begin
      tick;
      if (m_tx_start) seen = 1'b1;
    end
    checks++; if (seen !== 1'b1) begin errors++; $display("FAIL rbusy_start_seen: got %b expected 1", seen); end
    tick; tick; tick;
    reset = 1'b1; req = 3'b011;
    tick;
    checks++; if (grant !== 3'b000) begin errors++; $display("FAIL rbusy_grant: got %b expected 000", grant); end
    checks++; if (done !== 3'b000) begin errors++; $display("FAIL rbusy_done: got %b expected 000", done); end
    checks++; if (rx_data !== 8'h00) begin errors++; $display("FAIL rbusy_rx_data: got %h expected 00", rx_data); end
    checks++; if (m_tx_data !== 8'h00) begin errors++; $display("FAIL rbusy_m_tx_data: got %h expected 00", m_tx_data); end
    checks++; if ({m_tx_start, m_rx_start, timeout_err} !== 3'b000) begin errors++; $display("FAIL rbusy_strobes: got %b expected 000", {m_tx_start, m_rx_start, timeout_err}); end
    reset = 1'b0;
    tick;
    checks++; if (grant !== 3'b001) begin errors++; $display("FAIL rbusy_next_winner: got %b expected 001", grant); end
    req = 3'b000;
    for (int c = 0; c < 8; c++) begin
      tick;
      if (done == 3'b010) bad_done++;
    end
    checks++; if (bad_done !== 0) begin errors++; $display("FAIL rbusy_aborted_done: got %0d expected 0", bad_done); end
  endtask

  task automatic test_round_robin;
    logic [2:0] order [6];
    logic [2:0] exp_order [6];
    int gaps [6];
    int n, zeros;
    logic [2:0] prev;
    exp_order = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};
    n = 0; zeros = 0; prev = '0;
    for (int i = 0; i < 6; i++) begin order[i] = '0; gaps[i] = -1; end
    req = 3'b000; req_tx = 3'b000; req_rx = 3'b000;
    reset = 1'b1;
    tick;
    reset = 1'b0; req = 3'b111;
    for (int c = 0; c < 40; c++) begin
      tick;
      if (grant != 3'b000 && prev == 3'b000 && n < 6) begin
        order[n] = grant; gaps[n] = zeros; n++;
      end
      if (grant == 3'b000) zeros++; else zeros = 0;
      prev = grant;
    end
    req = 3'b000;
    checks++; if (n !== 6) begin errors++; $display("FAIL rr_grant_count: got %0d expected 6", n); end
    for (int i = 0; i < 6; i++) begin
      checks++; if (order[i] !== exp_order[i]) begin errors++; $display("FAIL rr_order_%0d: got %b expected %b", i, order[i], exp_order[i]); end
    end
    for (int i = 1; i < 6; i++) begin
      checks++; if (gaps[i] !== 1) begin errors++; $display("FAIL rr_gap_%0d: got %0d expected 1", i, gaps[i]); end
    end
    for (int c = 0; c < 6; c++) tick;
  endtask

  task automatic test_timeout;
    int cd, ts, to_cnt, to_at, d1_cnt, d1_at;
    logic g2;
    cd = -1; ts = -1; to_cnt = 0; to_at = -1; d1_cnt = 0; d1_at = -2; g2 = 1'b0;
    reset = 1'b1;
    tick;
    reset = 1'b0;
    req_tx_b = 3'b000; req_rx_b = 3'b001; req_b = 3'b001;
    for (int c = 0; c < 30; c++) begin
      tick;
      m_rx_valid_b = 1'b0;
      if (grant_b != 3'b000) req_b = 3'b000;
      if (m_rx_start_b) cd = 3;
      else if (cd > 0) begin
        cd--;
        if (cd == 0) begin m_rx_valid_b = 1'b1; m_rx_data_b = 8'h3C; end
      end
    end
    checks++; if (rx_data_b !== 8'h3C) begin errors++; $display("FAIL to_preload_rx_data: got %h expected 3c", rx_data_b); end
    req_tx_b = 3'b010; req_rx_b = 3'b010; req_tx_data_b = 24'h007700; req_b = 3'b110;
    for (int c = 0; c < 60; c++) begin
      tick;
      if (m_tx_start_b && ts < 0) ts = c;
      if (timeout_err_b) begin to_cnt++; to_at = c; end
      if (done_b == 3'b010) begin d1_cnt++; d1_at = c; end
      if (grant_b == 3'b010) req_b = req_b & 3'b101;
      if (grant_b == 3'b100) begin g2 = 1'b1; req_b = 3'b000; end
    end
    checks++; if (to_cnt !== 1) begin errors++; $display("FAIL to_pulse_count: got %0d expected 1", to_cnt); end
    checks++; if (to_at - ts !== 17 || ts < 0) begin errors++; $display("FAIL to_latency: got %0d expected 17", to_at - ts); end
    checks++; if (d1_cnt !== 1 || d1_at !== to_at) begin errors++; $display("FAIL to_done: got %0d pulses at %0d expected 1 at %0d", d1_cnt, d1_at, to_at); end
    checks++; if (rx_data_b !== 8'h3C) begin errors++; $display("FAIL to_rx_data_held: got %h expected 3c", rx_data_b); end
    checks++; if (g2 !== 1'b1) begin errors++; $display("FAIL to_next_grant: got %b expected 1", g2); end
  endtask

  initial begin
    checks = 0; errors = 0;
    reset = 1'b1;
    req = '0; req_tx = '0; req_rx = '0; req_tx_data = '0;
    m_tx_done = 1'b0; m_rx_valid = 1'b0; m_rx_data = '0;
    req_b = '0; req_tx_b = '0; req_rx_b = '0; req_tx_data_b = '0;
    m_tx_done_b = 1'b0; m_rx_valid_b = 1'b0; m_rx_data_b = '0;
    test_reset;
    test_single;
    test_tx_rx_zero;
    test_stray_and_drop;
    test_reset_busy;
    test_round_robin;
    test_timeout;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
